// File: rtl/alu.sv
// LEGv8 datapath ALU: 64-bit combinational result and status word, plus a
// condition-flag register loaded by flag-setting instructions.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [4:0]  FS,
  input  logic        set_flags,
  output logic [63:0] F,
  output logic [3:0]  status,
  output logic [3:0]  flags
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ORR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;

  logic [63:0] a2;
  logic [63:0] b2;
  logic [64:0] sum;
  logic [5:0]  shamt;
  logic        carry;
  logic        ovf;

  assign a2    = FS[1] ? ~A : A;
  assign b2    = FS[0] ? ~B : B;
  assign shamt = B[5:0];

  // FS[0] doubles as carry-in so that SUB is A + ~B + 1.
  assign sum = {1'b0, a2} + {1'b0, b2} + {64'd0, FS[0]};

  always_comb begin
    F     = 64'd0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (FS[4:2])
      OP_AND: F = a2 & b2;
      OP_ORR: F = a2 | b2;
      OP_ADD: begin
        F     = sum[63:0];
        carry = sum[64];
        ovf   = (a2[63] == b2[63]) && (sum[63] != a2[63]);
      end
      OP_XOR: F = a2 ^ b2;
      // Shifts deliberately use the raw operands; FS[1:0] are don't-cares.
      OP_LSL: F = A << shamt;
      OP_LSR: F = A >> shamt;
      default: F = 64'd0;
    endcase
  end

  assign status = {ovf, carry, F[63], (F == 64'd0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (set_flags) begin
      flags <= status;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed and random vector bench for the alu block: result, status word and
// the flag register's load, hold and asynchronous clear behaviour.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [63:0] A;
  logic [63:0] B;
  logic [4:0]  FS;
  logic        set_flags;
  logic [63:0] F;
  logic [3:0]  status;
  logic [3:0]  flags;

  int vec_cnt;
  int err_cnt;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .FS        (FS),
    .set_flags (set_flags),
    .F         (F),
    .status    (status),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: returns {status, F}.
  function automatic logic [67:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] fs);
    logic [63:0] x, y, r;
    logic [64:0] s;
    logic        c, v;
    x = fs[1] ? ~a : a;
    y = fs[0] ? ~b : b;
    c = 1'b0;
    v = 1'b0;
    r = 64'd0;
    case (fs[4:2])
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin
        s = {1'b0, x} + {1'b0, y} + {64'd0, fs[0]};
        r = s[63:0];
        c = s[64];
        v = (x[63] == y[63]) && (r[63] != x[63]);
      end
      3'd3: r = x ^ y;
      3'd4: r = a << b[5:0];
      3'd5: r = a >> b[5:0];
      default: r = 64'd0;
    endcase
    return {v, c, r[63], (r == 64'd0), r};
  endfunction

  task automatic apply(input logic [4:0] fs, input logic [63:0] a, input logic [63:0] b);
    FS = fs;
    A  = a;
    B  = b;
    #2;
  endtask

  initial begin
    logic [67:0] exp_v;
    vec_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    set_flags = 1'b0;
    A         = 64'd0;
    B         = 64'd0;
    FS        = 5'd0;

    #12;
    check("flags_in_reset", {60'd0, flags}, 64'h0);

    // Directed combinational vectors with hand-computed results.
    apply(5'b00000, 64'd2, 64'd5);
    check("and_f", F, 64'd0);
    check("and_st", {60'd0, status}, 64'h1);
    apply(5'b00100, 64'd2, 64'd5);
    check("orr_f", F, 64'd7);
    check("orr_st", {60'd0, status}, 64'h0);
    apply(5'b01000, 64'd1, 64'd15);
    check("add_f", F, 64'd16);
    check("add_st", {60'd0, status}, 64'h0);
    apply(5'b01001, 64'd1, 64'd15);
    check("sub_f", F, 64'hFFFF_FFFF_FFFF_FFF2);
    check("sub_st", {60'd0, status}, 64'h2);
    apply(5'b01001, 64'd15, 64'd1);
    check("sub_noborrow_st", {60'd0, status}, 64'h4);
    apply(5'b01001, 64'd7, 64'd7);
    check("sub_eq_st", {60'd0, status}, 64'h5);
    apply(5'b01000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("ovf_f", F, 64'h8000_0000_0000_0000);
    check("ovf_st", {60'd0, status}, 64'hA);
    apply(5'b01000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("add_carry_st", {60'd0, status}, 64'h5);
    apply(5'b10000, 64'd1, 64'd15);
    check("lsl_f", F, 64'h8000);
    apply(5'b10011, 64'd1, 64'hFFFF_FFFF_FFFF_FFC0);
    check("lsl_zero_ignhi", F, 64'd1);
    apply(5'b10000, 64'd1, 64'd63);
    check("lsl_63_f", F, 64'h8000_0000_0000_0000);
    check("lsl_63_st", {60'd0, status}, 64'h2);
    apply(5'b10100, 64'h8000_0000_0000_0000, 64'd15);
    check("lsr_f", F, 64'h0001_0000_0000_0000);
    apply(5'b10100, 64'h8000_0000_0000_0000, 64'd63);
    check("lsr_63_f", F, 64'd1);
    apply(5'b01100, 64'd3, 64'd6);
    check("xor_f", F, 64'd5);
    apply(5'b00010, 64'd0, 64'h00FF);
    check("bic_inva_f", F, 64'h00FF);
    apply(5'b11000, 64'd123, 64'd456);
    check("unused_f", F, 64'd0);
    check("unused_st", {60'd0, status}, 64'h1);
    apply(5'b11111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    check("unused7_f", F, 64'd0);

    // Flag register: load, hold, async clear.
    @(negedge clk);
    rst_n     = 1'b1;
    set_flags = 1'b1;
    FS        = 5'b01001;
    A         = 64'd1;
    B         = 64'd15;
    @(posedge clk);
    #1;
    check("flags_load_sub", {60'd0, flags}, 64'h2);
    @(negedge clk);
    set_flags = 1'b0;
    FS        = 5'b00000;
    A         = 64'd0;
    B         = 64'd0;
    @(posedge clk);
    #1;
    check("flags_hold", {60'd0, flags}, 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("flags_async_clr", {60'd0, flags}, 64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    set_flags = 1'b1;
    FS        = 5'b01000;
    A         = 64'h7FFF_FFFF_FFFF_FFFF;
    B         = 64'd1;
    @(posedge clk);
    #1;
    check("flags_load_ovf", {60'd0, flags}, 64'hA);
    @(negedge clk);
    set_flags = 1'b0;

    // Random sweep against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] ra, rb;
      logic [4:0]  rf;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rf = 5'($urandom_range(0, 31));
      if (i % 4 == 0) ra = ra >> $urandom_range(0, 63);
      apply(rf, ra, rb);
      exp_v = ref_alu(ra, rb, rf);
      check("rand_f", F, exp_v[63:0]);
      check("rand_st", {60'd0, status}, {60'd0, exp_v[67:64]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
